// File: rtl/button_conditioner_if.sv
// Pushbutton conditioner bundle: raw active-low pins in, clean levels/pulses/tick out.
// Latency: none (plain wires between conditioner and its consumers).
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface button_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             ms_tick;

    // Conditioner side: samples the pins and produces the clean view.
    modport master (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output ms_tick
    );

    // Pin driver / consumer side.
    modport slave (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  ms_tick
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise and debounce active-low pushbuttons; emit clean level, press/release pulses, ms tick.
// Latency: 2 sync flops + DEBOUNCE_MS ticks of stable input (tick phase gives a one-tick spread).
// Backpressure: none; pins are sampled every clk and pulses are one cycle wide, never held.
module button_conditioner #(
    parameter int N_BTN       = 3,
    parameter int TICK_DIV    = 50_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.master  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_MS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_MS - 1);

    typedef enum logic [1:0] {
        REL    = 2'd0,
        WAIT_P = 2'd1,
        PRS    = 2'd2,
        WAIT_R = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [PW-1:0]    presc;
    logic             ms_tick_q;

    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [CW-1:0]    cnt_q   [N_BTN];
    logic [CW-1:0]    cnt_d   [N_BTN];
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] rel_q,   rel_d;

    // Two-flop synchroniser; idles high so an unpressed button looks released after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
        end
    end

    // Free-running prescaler; the tick is registered off the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            ms_tick_q <= 1'b0;
        end else begin
            ms_tick_q <= (presc == PRESC_LAST);
            presc     <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    // Channel state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= REL;
                cnt_q[i]   <= '0;
            end
            level_q <= '1;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Debounce decisions: a glitch always beats a coincident tick and restarts the count.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                REL: begin
                    if (!sync2[i]) begin
                        state_d[i] = WAIT_P;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_P: begin
                    if (sync2[i]) begin
                        state_d[i] = REL;
                        cnt_d[i]   = '0;
                    end else if (ms_tick_q) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = PRS;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b0;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                PRS: begin
                    if (sync2[i]) begin
                        state_d[i] = WAIT_R;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_R: begin
                    if (!sync2[i]) begin
                        state_d[i] = PRS;
                        cnt_d[i]   = '0;
                    end else if (ms_tick_q) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = REL;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b1;
                            rel_d[i]   = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i] = REL;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = rel_q;
    assign bus.ms_tick     = ms_tick_q;
endmodule
